// File: rtl/oam_dma_if.sv
// rtl/oam_dma_if.sv - CPU-side and DMA-side bus signals of the sprite DMA engine
//
// Purpose: bundles the CPU trigger bus, the memory read-data return and the
// DMA bus-master outputs so the controller and its surroundings share one port.
// Modports:
//   master : the DMA controller (samples cpu_* and bus_din, drives cpu_halt/dma_*)
//   slave  : the system side (CPU, memory mux, PPU) facing the controller
interface oam_dma_if;
    logic        cpu_en;
    logic        cpu_write;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic [7:0]  bus_din;
    logic        cpu_halt;
    logic        dma_active;
    logic        dma_en;
    logic        dma_write;
    logic [15:0] dma_addr;
    logic [7:0]  dma_dout;
    logic        dma_done;

    modport master (
        input  cpu_en, cpu_write, cpu_addr, cpu_dout, bus_din,
        output cpu_halt, dma_active, dma_en, dma_write, dma_addr, dma_dout, dma_done
    );

    modport slave (
        output cpu_en, cpu_write, cpu_addr, cpu_dout, bus_din,
        input  cpu_halt, dma_active, dma_en, dma_write, dma_addr, dma_dout, dma_done
    );
endinterface

// File: rtl/oam_dma_ctrl.sv
// rtl/oam_dma_ctrl.sv - sprite DMA engine copying one 256-byte page into the PPU OAM port
//
// Purpose: a CPU write of page P to TRIG_ADDR halts the CPU and copies bytes
// P*256..P*256+255 in order to OAM_PORT, one read and one write per byte.
// Ports:
//   clk    : CPU-domain clock, all state changes on posedge
//   reset  : asynchronous active-low reset
//   bus    : oam_dma_if.master (cpu_* trigger inputs, bus_din read data,
//            cpu_halt/dma_active/dma_en/dma_write/dma_addr/dma_dout/dma_done)
// Parameters:
//   TRIG_ADDR    : CPU write address that starts a transfer
//   OAM_PORT     : PPU OAM data register written per byte
//   READ_LATENCY : cycles from dma_addr valid to bus_din valid (>= 1)
module oam_dma_ctrl #(
    parameter logic [15:0] TRIG_ADDR    = 16'h4014,
    parameter logic [15:0] OAM_PORT     = 16'h2004,
    parameter int          READ_LATENCY = 1
) (
    input  logic      clk,
    input  logic      reset,
    oam_dma_if.master bus
);

    localparam logic [7:0] LAT = 8'(READ_LATENCY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t     state;
    logic [7:0] page;
    logic [7:0] idx;
    logic [7:0] wait_cnt;

    logic trigger;
    assign trigger = bus.cpu_en && bus.cpu_write && (bus.cpu_addr == TRIG_ADDR);

    // Outputs are registered: each transition loads the values the next
    // state presents, so every output is valid for exactly that state's cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            page           <= 8'h00;
            idx            <= 8'h00;
            wait_cnt       <= 8'h00;
            bus.cpu_halt   <= 1'b0;
            bus.dma_active <= 1'b0;
            bus.dma_en     <= 1'b0;
            bus.dma_write  <= 1'b0;
            bus.dma_addr   <= 16'h0000;
            bus.dma_dout   <= 8'h00;
            bus.dma_done   <= 1'b0;
        end else begin
            bus.dma_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (trigger) begin
                        page           <= bus.cpu_dout;
                        idx            <= 8'h00;
                        state          <= S_ALIGN;
                        bus.cpu_halt   <= 1'b1;
                        bus.dma_active <= 1'b1;
                        bus.dma_en     <= 1'b0;
                        bus.dma_write  <= 1'b0;
                    end
                end
                S_ALIGN: begin
                    state         <= S_READ;
                    bus.dma_en    <= 1'b1;
                    bus.dma_write <= 1'b0;
                    bus.dma_addr  <= {page, idx};
                end
                S_READ: begin
                    wait_cnt   <= LAT;
                    state      <= S_WAIT;
                    bus.dma_en <= 1'b0;
                end
                S_WAIT: begin
                    // Last wait cycle: bus_din now carries the byte addressed in READ.
                    if (wait_cnt == 8'd1) begin
                        wait_cnt      <= 8'd0;
                        bus.dma_dout  <= bus.bus_din;
                        state         <= S_WRITE;
                        bus.dma_en    <= 1'b1;
                        bus.dma_write <= 1'b1;
                        bus.dma_addr  <= OAM_PORT;
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
                end
                S_WRITE: begin
                    if (idx == 8'hFF) begin
                        state          <= S_DONE;
                        bus.dma_done   <= 1'b1;
                        bus.cpu_halt   <= 1'b0;
                        bus.dma_active <= 1'b0;
                        bus.dma_en     <= 1'b0;
                        bus.dma_write  <= 1'b0;
                        bus.dma_addr   <= 16'h0000;
                    end else begin
                        // Only the low byte advances, so the source stays inside the page.
                        idx           <= idx + 8'd1;
                        state         <= S_READ;
                        bus.dma_en    <= 1'b1;
                        bus.dma_write <= 1'b0;
                        bus.dma_addr  <= {page, idx + 8'd1};
                    end
                end
                S_DONE: begin
                    // A trigger landing here is dropped; IDLE is the only state that listens.
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
